// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB-first, optional parity,
// STOP_BITS stop bits, paced by an external clken tick. Parity bit present when UART_TX_PARITY_EN is defined.
module uart_tx_param #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk_50m,
    input  logic                 rst,
    input  logic                 clken,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic [1:0]    STOP_LAST = 2'(STOP_BITS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic       ODD_BIT  = (PARITY_ODD != 0);
`endif

    if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_tx_param: illegal parameter value");
    end

    logic [2:0]           state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [BW-1:0]        bitcnt_q, bitcnt_d;
    logic [1:0]           stopcnt_q, stopcnt_d;
    logic                 tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        stopcnt_d = stopcnt_q;
        tx_d      = tx_q;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                // clken deliberately ignored here so the start bit is a full interval
                if (data_valid) begin
                    shreg_d   = data_in;
                    bitcnt_d  = '0;
                    stopcnt_d = '0;
`ifdef UART_TX_PARITY_EN
                    par_d     = 1'b0;
`endif
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (clken) begin
                    tx_d    = 1'b0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (clken) begin
                    tx_d     = shreg_q[0];
                    shreg_d  = shreg_q >> 1;
                    bitcnt_d = bitcnt_q + 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_d    = par_q ^ shreg_q[0];
                    if (bitcnt_q == LAST_BIT) state_d = S_PARITY;
`else
                    if (bitcnt_q == LAST_BIT) state_d = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (clken) begin
                    tx_d    = par_q ^ ODD_BIT;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // the tick after the last stop interval ends the frame
                if (clken) begin
                    stopcnt_d = stopcnt_q + 2'd1;
                    tx_d      = 1'b1;
                    if (stopcnt_q == STOP_LAST) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            stopcnt_q <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            stopcnt_q <= stopcnt_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign tx         = tx_q;
    assign data_ready = (state_q == S_IDLE);
    assign tx_busy    = (state_q != S_IDLE);
    assign tx_done    = (state_q == S_STOP) && clken && (stopcnt_q == STOP_LAST);

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: frame-list model compared every cycle on three
// instances (8N1, 7 data/2 stop, odd parity sense) plus hand-computed frame literals.
module tb_uart_tx_param;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       clken;
    logic [8:0] din [3];
    logic [2:0] vld;
    logic [2:0] rdy_w, tx_w, busy_w, done_w;

    always #10 clk = ~clk;

    uart_tx_param #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut (
        .clk_50m(clk), .rst(rst), .clken(clken), .data_in(din[0][7:0]), .data_valid(vld[0]),
        .data_ready(rdy_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));

    uart_tx_param #(.DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(0)) u_dut7 (
        .clk_50m(clk), .rst(rst), .clken(clken), .data_in(din[1][6:0]), .data_valid(vld[1]),
        .data_ready(rdy_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));

    uart_tx_param #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) u_dut_odd (
        .clk_50m(clk), .rst(rst), .clken(clken), .data_in(din[2][7:0]), .data_valid(vld[2]),
        .data_ready(rdy_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: list of line levels per frame ----------------
    int db_a  [3] = '{8, 7, 8};
    int sb_a  [3] = '{1, 2, 1};
    int odd_a [3] = '{0, 0, 1};

    logic        m_tx    [3];
    bit          m_busy  [3];
    int          m_tick  [3];
    int          m_len   [3];
    logic [15:0] m_frame [3];

    function automatic logic [15:0] frame_of(input int i, input logic [8:0] d, output int len);
        logic [15:0] f;
        logic        p;
        int          k;
        f = '0;
        p = 1'b0;
        k = 1;                       // bit 0 is the start bit (0)
        for (int j = 0; j < db_a[i]; j++) begin
            f[k] = d[j];
            p    = p ^ d[j];
            k++;
        end
        if (PAR == 1) begin
            f[k] = p ^ (odd_a[i] != 0);
            k++;
        end
        for (int j = 0; j < sb_a[i]; j++) begin
            f[k] = 1'b1;
            k++;
        end
        len = k;
        return f;
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_tx[i] = 1'b1; m_busy[i] = 1'b0; m_tick[i] = 0; m_len[i] = 0; m_frame[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("cyc_tx[%0d]", i),    16'(tx_w[i]),   16'(m_tx[i]));
                chk($sformatf("cyc_busy[%0d]", i),  16'(busy_w[i]), 16'(m_busy[i]));
                chk($sformatf("cyc_ready[%0d]", i), 16'(rdy_w[i]),  16'(!m_busy[i]));
                chk($sformatf("cyc_done[%0d]", i),  16'(done_w[i]),
                    16'(m_busy[i] && clken && (m_tick[i] == m_len[i])));
                // advance to the state after the coming posedge
                if (rst) begin
                    m_busy[i] = 1'b0;
                    m_tx[i]   = 1'b1;
                end else if (!m_busy[i]) begin
                    if (vld[i]) begin
                        m_busy[i]  = 1'b1;
                        m_tick[i]  = 0;
                        m_frame[i] = frame_of(i, din[i], m_len[i]);
                    end
                end else if (clken) begin
                    m_tick[i]++;
                    if (m_tick[i] <= m_len[i]) m_tx[i] = m_frame[i][m_tick[i]-1];
                    else                       m_busy[i] = 1'b0;
                end
            end
        end
    end

    // ---------------- baud tick: one cycle in sixteen ----------------
    int phase = 0;
    initial begin
        clken = 1'b0;
        forever begin
            @(posedge clk); #1;
            phase = (phase + 1) % 16;
            clken = (phase == 0);
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic wait_accept(input int i, input logic [8:0] d, input bit keep);
        int t;
        din[i] = d;
        vld[i] = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!rdy_w[i] && t < 1000);
        chk($sformatf("accept_in_time[%0d]", i), 16'(t < 1000), 16'd1);
        @(posedge clk); #1;
        if (!keep) vld[i] = 1'b0;
    endtask

    // Samples tx once per bit interval (at the tick closing it) and records the done tick.
    task automatic capture(input int i, input int nbits, output logic [15:0] bits, output int done_tick);
        int tick, t;
        tick = 0; t = 0; bits = '0; done_tick = 0;
        while (tick < nbits + 1 && t < 4000) begin
            @(negedge clk);
            t++;
            if (clken) begin
                tick++;
                if (tick >= 2) bits[tick-2] = tx_w[i];
                if (done_w[i]) done_tick = tick;
            end
        end
        chk($sformatf("frame_in_time[%0d]", i), 16'(t < 4000), 16'd1);
    endtask

    logic [15:0] bits;
    int          dt;

    initial begin
        rst = 1'b1;
        vld = '0;
        for (int i = 0; i < 3; i++) din[i] = '0;

        // 1: reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_tx",    16'(tx_w[0]),   16'd1);
        chk("reset_busy",  16'(busy_w[0]), 16'd0);
        chk("reset_ready", 16'(rdy_w[0]),  16'd1);
        chk("reset_done",  16'(done_w[0]), 16'd0);
        @(posedge clk); #1;

        // 2/3: 0xA5 on the 8-bit instance, with stray valid pulses while busy
        wait_accept(0, 9'h0A5, 1'b0);
        fork
            capture(0, 10 + PAR, bits, dt);
            begin
                repeat (5) begin
                    @(posedge clk); #1; vld[0] = 1'b1; din[0] = 9'h1FF;
                    @(posedge clk); #1; vld[0] = 1'b0;
                    repeat (10) @(posedge clk);
                end
            end
        join
`ifdef UART_TX_PARITY_EN
        chk("a5_even_bits", bits, 16'h054A);
        chk("a5_done_tick", 16'(dt - 1), 16'd11);
`else
        chk("a5_8n1_bits", bits, 16'h034A);
        chk("a5_done_tick", 16'(dt - 1), 16'd10);
`endif
        @(negedge clk);
        chk("a5_idle_after_done", 16'(busy_w[0]), 16'd0);
        @(posedge clk); #1;

        wait_accept(2, 9'h0A5, 1'b0);
        capture(2, 10 + PAR, bits, dt);
`ifdef UART_TX_PARITY_EN
        chk("a5_odd_bits", bits, 16'h074A);
`else
        chk("a5_odd_inst_bits", bits, 16'h034A);
`endif
        @(posedge clk); #1;

        // 4: 7 data bits, 2 stop bits
        wait_accept(1, 9'h07F, 1'b0);
        capture(1, 10 + PAR, bits, dt);
`ifdef UART_TX_PARITY_EN
        chk("7f_7d2s_bits", bits, 16'h07FE);
        chk("7f_done_tick", 16'(dt - 1), 16'd11);
`else
        chk("7f_7d2s_bits", bits, 16'h03FE);
        chk("7f_done_tick", 16'(dt - 1), 16'd10);
`endif
        @(posedge clk); #1;

        // 5: held valid, 0x3C then 0xC3
        wait_accept(0, 9'h03C, 1'b1);
        din[0] = 9'h0C3;
        capture(0, 10 + PAR, bits, dt);
`ifdef UART_TX_PARITY_EN
        chk("3c_bits", bits, 16'h0478);
`else
        chk("3c_bits", bits, 16'h0278);
`endif
        chk("hs_ready_on_done", 16'(rdy_w[0]), 16'd0);
        @(negedge clk);
        chk("hs_ready_after_done", 16'(rdy_w[0]), 16'd1);
        @(posedge clk); #1;
        vld[0] = 1'b0;
        @(negedge clk);
        chk("hs_second_taken", 16'(busy_w[0]), 16'd1);
        capture(0, 10 + PAR, bits, dt);
`ifdef UART_TX_PARITY_EN
        chk("c3_bits", bits, 16'h0586);
`else
        chk("c3_bits", bits, 16'h0386);
`endif
        @(posedge clk); #1;

        // 6: reset during data bit 3, then a clean frame
        wait_accept(0, 9'h0A5, 1'b0);
        begin
            int tk, t;
            tk = 0; t = 0;
            while (tk < 5 && t < 1000) begin
                @(negedge clk);
                t++;
                if (clken) tk++;
            end
            chk("abort_reach_bit3", 16'(t < 1000), 16'd1);
        end
        @(posedge clk); #1;
        chk("abort_tx_is_bit3", 16'(tx_w[0]), 16'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_tx",   16'(tx_w[0]),   16'd1);
        chk("abort_busy", 16'(busy_w[0]), 16'd0);
        chk("abort_done", 16'(done_w[0]), 16'd0);
        @(posedge clk); #1;
        wait_accept(0, 9'h05A, 1'b0);
        capture(0, 10 + PAR, bits, dt);
`ifdef UART_TX_PARITY_EN
        chk("5a_after_abort_bits", bits, 16'h04B4);
`else
        chk("5a_after_abort_bits", bits, 16'h02B4);
`endif
        repeat (20) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
